risc_v_lsu: RTL
===============

// Module: risc_v_lsu
// PURPOSE
//  Load/store unit directly upstream of risc_v_memory (word-addressed, comb read, posedge write).
//  Accepts byte-addressed RISC-V loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) via valid/ready.
//  Implements sub-word stores as registered read-modify-write; sign/zero-extends loads.
//  Flags misaligned or illegal accesses without touching memory.
// PARAMETERS
//  DATA_WIDTH  32  word width; fixed at 32 for RV32 lane logic
//  ADDR_WIDTH  5   word-address width of the attached memory; byte address = ADDR_WIDTH+2
// PORTS
//  clk              in   1             clock; all state on posedge
//  rst              in   1             asynchronous, active-high reset
//  req_valid        in   1             request present
//  req_ready        out  1             high only in IDLE; accept = req_valid & req_ready
//  req_we           in   1             1 = store, 0 = load
//  req_funct3       in   3             RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//  req_addr         in   ADDR_WIDTH+2  byte address
//  req_wdata        in   DATA_WIDTH    store data, right-aligned
//  resp_valid       out  1             one-cycle pulse, request complete
//  resp_rdata       out  DATA_WIDTH    extended load data; 0 for stores/faults
//  resp_misaligned  out  1             valid with resp_valid; access rejected
//  mem_write        out  1             to memory mem_write
//  mem_addr         out  ADDR_WIDTH    to memory addr = latched req_addr[ADDR_WIDTH+1:2]
//  mem_wdata        out  DATA_WIDTH    to memory data_in
//  mem_rdata        in   DATA_WIDTH    from memory data_out (combinational)
// BEHAVIOUR
//  Reset: state IDLE; resp_valid=0, resp_rdata=0, resp_misaligned=0, mem_write=0, mem_wdata=0,
//   latched addr/funct3/we/wdata/rd_buf=0 (so mem_addr=0).
//  FSM IDLE->READ->(WRITE)->RESP->IDLE; no response backpressure.
//   IDLE : req_ready=1. On accept latch we/funct3/addr/wdata. Fault -> RESP (misaligned=1).
//          Load or SB/SH -> READ. SW -> WRITE (no read).
//   READ : rd_buf <= mem_rdata. Load -> RESP; SB/SH -> WRITE.
//   WRITE: mem_write=1 (comb from state), mem_wdata = merged word; memory commits at next edge.
//   RESP : resp_valid=1 for exactly one cycle; resp_rdata/resp_misaligned registered on entry.
//  Latency accept->resp_valid: fault 1, SW 2, load 2, SB/SH 3 cycles; next accept 1 cycle after RESP.
//  Fault: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 in {011,110,111}; store with funct3 BU/HU.
//   Faults never assert mem_write.
//  Lane select byte = addr[1:0], half = addr[1]. Merge: SB replaces rd_buf byte lane with wdata[7:0];
//   SH replaces half lane with wdata[15:0]; other lanes = rd_buf. SW: mem_wdata = wdata.
//  Load extract: B/H sign-extend lane MSB; BU/HU zero-extend; W passthrough.
//  mem_addr always from latched addr (stable through READ/WRITE; mem_rdata valid same cycle).
//  req_addr upper bits beyond ADDR_WIDTH+2 do not exist; max address wraps naturally, no check.
//  Reset mid-op: async rst clears state and drops mem_write before the next edge; the pending
//   write is abandoned (memory unchanged), no resp_valid is produced.
//  req_* inputs ignored outside IDLE.
// STRUCTURE
//  risc_v_lsu_pkg: funct3 localparams (F3_B..F3_HU), state encoding (IDLE,READ,WRITE,RESP, 2-bit).
//  Sub-module risc_v_lane_align (combinational): store merge + load extract from
//   {funct3, addr[1:0], rd_buf, wdata}; instantiated once in risc_v_lsu.
// TESTING
//  Bench instantiates risc_v_lsu + risc_v_memory. Directed:
//  1 SW 0x0C<-0xDEADBEEF, then LW 0x0C -> resp_rdata=0xDEADBEEF, SW resp 2 cycles after accept.
//  2 After 1: SB 0x0D<-0x55, LW 0x0C -> 0xDEAD55EF; LB 0x0F -> 0xFFFFFFDE; LBU 0x0F -> 0x000000DE.
//  3 SH 0x12<-0x8001 over 0x11223344 at word 4 -> word 0x80013344; LH 0x12 -> 0xFFFF8001,
//    LHU 0x12 -> 0x00008001.
//  4 LW 0x0D, SH 0x03, funct3=011 -> resp_misaligned=1 after 1 cycle, mem_write never high, memory intact.
//  5 Back-to-back req_valid held high: req_ready low in READ/WRITE/RESP; each request served once, in order.
//  6 Assert rst during WRITE of SB 0x08 -> mem_write low immediately, word 2 unchanged, no resp_valid,
//    req_ready=1 after release.

Source files
------------

// File: rtl/risc_v_lsu_pkg.sv
// Shared constants for the RV32 load/store unit: funct3 codes, FSM encoding, fault rule.
package risc_v_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Unsigned widths have no store form, so stores with BU/HU are rejected too.
    function automatic logic is_fault(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
        case (funct3)
            F3_B:    is_fault = 1'b0;
            F3_BU:   is_fault = we;
            F3_H:    is_fault = addr_lo[0];
            F3_HU:   is_fault = we | addr_lo[0];
            F3_W:    is_fault = (addr_lo != 2'b00);
            default: is_fault = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/risc_v_lane_align.sv
// Byte-lane steering: merges store data into the read-back word and extracts/extends load data.
module risc_v_lane_align
    import risc_v_lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rd_buf,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_load_word,
    output logic [31:0] o_store_word,
    output logic [31:0] o_load_data
);

    logic [3:0] w_hit;
    logic [7:0] w_src [4];
    logic [7:0] w_byte;
    logic [15:0] w_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_hit[gi] = (i_funct3 == F3_B) ? (i_addr_lo == 2'(gi)) :
                               (i_funct3 == F3_H) ? (i_addr_lo[1] == 1'(gi / 2)) : 1'b1;
            assign w_src[gi] = (i_funct3 == F3_B) ? i_wdata[7:0] :
                               (i_funct3 == F3_H) ? i_wdata[8*(gi%2) +: 8] :
                                                    i_wdata[8*gi +: 8];
            assign o_store_word[8*gi +: 8] = w_hit[gi] ? w_src[gi] : i_rd_buf[8*gi +: 8];
        end
    endgenerate

    // Load extraction works on the live memory word so the result can be registered on READ exit.
    assign w_byte = i_load_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];

    always_comb begin
        o_load_data = 32'd0;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'd0, w_half};
            F3_W:    o_load_data = i_load_word;
            default: o_load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/risc_v_lsu.sv
// RV32 load/store unit in front of a word memory; sub-word stores use read-modify-write.
module risc_v_lsu
    import risc_v_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_misaligned,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    logic [1:0]            r_state;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rd_buf;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                  r_resp_mis;

    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_store_word;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign req_ready       = (r_state == ST_IDLE);
    assign w_accept        = req_valid & req_ready;
    assign resp_valid      = (r_state == ST_RESP);
    assign resp_rdata      = r_resp_rdata;
    assign resp_misaligned = r_resp_mis;
    assign mem_addr        = r_addr[ADDR_WIDTH+1:2];
    // Write strobe is decoded from state so an async reset drops it without waiting for an edge.
    assign mem_write       = (r_state == ST_WRITE);
    assign mem_wdata       = mem_write ? w_store_word : '0;

    risc_v_lane_align u_lane_align (
        .i_funct3     (r_funct3),
        .i_addr_lo    (r_addr[1:0]),
        .i_rd_buf     (r_rd_buf),
        .i_wdata      (r_wdata),
        .i_load_word  (mem_rdata),
        .o_store_word (w_store_word),
        .o_load_data  (w_load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rd_buf     <= '0;
            r_resp_rdata <= '0;
            r_resp_mis   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        if (is_fault(req_we, req_funct3, req_addr[1:0])) begin
                            r_resp_rdata <= '0;
                            r_resp_mis   <= 1'b1;
                            r_state      <= ST_RESP;
                        end else if (req_we && (req_funct3 == F3_W)) begin
                            r_state <= ST_WRITE;
                        end else begin
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    r_rd_buf <= mem_rdata;
                    if (r_we) begin
                        r_state <= ST_WRITE;
                    end else begin
                        r_resp_rdata <= w_load_data;
                        r_resp_mis   <= 1'b0;
                        r_state      <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    r_resp_rdata <= '0;
                    r_resp_mis   <= 1'b0;
                    r_state      <= ST_RESP;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
